regfile_2r1w_sb: RTL and testbench

- Parametrised successor to the single-port register file.
- Provides one write port and two asynchronous read ports, each with optional write-to-read bypass.
- Register 0 can optionally be hardwired to zero.
- After reset, a sequential clear engine zeroes every entry, one per cycle, before the file accepts traffic.
- A per-register busy scoreboard lets the decode/hazard stage reserve a destination and see it released when the write lands.

---
 rtl/regfile_2r1w_sb.sv | 172 +++++++++++++++++
 tb/tb_regfile_2r1w_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: register file with one write port, two combinational read
// ports, optional write-to-read bypass, optional hardwired-zero entry 0, a
// per-entry busy scoreboard and a post-reset sequential clear sweep.
module regfile_2r1w_sb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_e,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [WIDTH-1:0]  reg_write_data,
  input  logic              reserve_e,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] reg_read_addr_a,
  output logic [WIDTH-1:0]  reg_read_data_a,
  output logic              reg_busy_a,
  input  logic [ADDR_W-1:0] reg_read_addr_b,
  output logic [WIDTH-1:0]  reg_read_data_b,
  output logic              reg_busy_b,
  output logic              init_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [WIDTH-1:0]  DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                init_done_q, init_done_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];

  logic                ready_s;
  logic                wr_ok_s;
  logic                res_ok_s;
  logic                byp_a_s;
  logic                byp_b_s;

  // Qualify write/reserve requests: entry 0 drops them when hardwired to zero.
  always_comb begin
    ready_s  = (state_q == READY);
    wr_ok_s  = reg_write_e && !(ZERO_REG && (reg_write_dest == ADDR_ZERO));
    res_ok_s = reserve_e && !(ZERO_REG && (reserve_addr == ADDR_ZERO));
    byp_a_s  = BYPASS && reg_write_e && (reg_write_dest == reg_read_addr_a);
    byp_b_s  = BYPASS && reg_write_e && (reg_write_dest == reg_read_addr_b);
  end

  // Next-state logic: clear sweep in CLEAR, write/reserve traffic in READY.
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    init_done_d = init_done_q;
    busy_d      = busy_q;
    mem_d       = mem_q;
    case (state_q)
      CLEAR: begin
        mem_d[clr_ptr_q] = DATA_ZERO;
        clr_ptr_d        = clr_ptr_q + ADDR_ONE;
        if (clr_ptr_q == ADDR_LAST) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end else begin
          state_d     = CLEAR;
          init_done_d = 1'b0;
        end
      end
      READY: begin
        // Write first so that a same-cycle reservation of the same entry wins.
        if (wr_ok_s) begin
          mem_d[reg_write_dest]  = reg_write_data;
          busy_d[reg_write_dest] = 1'b0;
        end else begin
          busy_d = busy_q;
        end
        if (res_ok_s) begin
          busy_d[reserve_addr] = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q;
        end
      end
      default: begin
        state_d     = CLEAR;
        clr_ptr_d   = ADDR_ZERO;
        init_done_d = 1'b0;
        busy_d      = {DEPTH{1'b0}};
      end
    endcase
  end

  // Control state register with synchronous reset that restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= ADDR_ZERO;
      init_done_q <= 1'b0;
      busy_q      <= {DEPTH{1'b0}};
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Storage array; the reset edge leaves contents alone, the sweep clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Read port A data: clear state, hardwired zero, bypass, then array.
  always_comb begin
    if (!ready_s) begin
      reg_read_data_a = DATA_ZERO;
    end else if (ZERO_REG && (reg_read_addr_a == ADDR_ZERO)) begin
      reg_read_data_a = DATA_ZERO;
    end else if (byp_a_s) begin
      reg_read_data_a = reg_write_data;
    end else begin
      reg_read_data_a = mem_q[reg_read_addr_a];
    end
  end

  // Read port B data: same priority chain as port A.
  always_comb begin
    if (!ready_s) begin
      reg_read_data_b = DATA_ZERO;
    end else if (ZERO_REG && (reg_read_addr_b == ADDR_ZERO)) begin
      reg_read_data_b = DATA_ZERO;
    end else if (byp_b_s) begin
      reg_read_data_b = reg_write_data;
    end else begin
      reg_read_data_b = mem_q[reg_read_addr_b];
    end
  end

  // Busy flags: suppressed in CLEAR, on hardwired zero, and by a landing write.
  always_comb begin
    if (!ready_s) begin
      reg_busy_a = 1'b0;
      reg_busy_b = 1'b0;
    end else begin
      if ((ZERO_REG && (reg_read_addr_a == ADDR_ZERO)) || byp_a_s) begin
        reg_busy_a = 1'b0;
      end else begin
        reg_busy_a = busy_q[reg_read_addr_a];
      end
      if ((ZERO_REG && (reg_read_addr_b == ADDR_ZERO)) || byp_b_s) begin
        reg_busy_b = 1'b0;
      end else begin
        reg_busy_b = busy_q[reg_read_addr_b];
      end
    end
  end

  assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// tb_regfile_2r1w_sb: drives two configurations of the register file from one
// stimulus stream (ZERO_REG=0/BYPASS=1 and ZERO_REG=1/BYPASS=0) and compares
// every output each cycle against a behavioural model of the file.
module tb_regfile_2r1w_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  wd = 4'd0;
  logic [15:0] wdat = 16'd0;
  logic        res = 1'b0;
  logic [3:0]  ra = 4'd0;
  logic [3:0]  aa = 4'd0;
  logic [3:0]  ab = 4'd0;

  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic        ba0, bb0, ba1, bb1, id0, id1;

  int checks = 0;
  int errors = 0;

  // model state per configuration (index 0: bypass, index 1: zero-reg)
  logic [15:0] mem_m  [2][16];
  bit          busy_m [2][16];
  int          cnt_m  [2];
  bit          rdy_m  [2];

  always #5 clk = ~clk;

  regfile_2r1w_sb #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .reg_write_e(we), .reg_write_dest(wd), .reg_write_data(wdat),
    .reserve_e(res), .reserve_addr(ra),
    .reg_read_addr_a(aa), .reg_read_data_a(rda0), .reg_busy_a(ba0),
    .reg_read_addr_b(ab), .reg_read_data_b(rdb0), .reg_busy_b(bb0),
    .init_done(id0));

  regfile_2r1w_sb #(.WIDTH(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .reg_write_e(we), .reg_write_dest(wd), .reg_write_data(wdat),
    .reserve_e(res), .reserve_addr(ra),
    .reg_read_addr_a(aa), .reg_read_data_a(rda1), .reg_busy_a(ba1),
    .reg_read_addr_b(ab), .reg_read_data_b(rdb1), .reg_busy_b(bb1),
    .init_done(id1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int c, input logic [3:0] a);
    if (!rdy_m[c]) return 32'd0;
    if (c == 1 && a == 4'd0) return 32'd0;
    if (c == 0 && we && wd == a) return {16'd0, wdat};
    return {16'd0, mem_m[c][a]};
  endfunction

  function automatic logic [31:0] exp_busy(input int c, input logic [3:0] a);
    if (!rdy_m[c]) return 32'd0;
    if (c == 1 && a == 4'd0) return 32'd0;
    if (c == 0 && we && wd == a) return 32'd0;
    return {31'd0, busy_m[c][a]};
  endfunction

  task automatic check_all();
    check_eq("c0_rd_a", {16'd0, rda0}, exp_rd(0, aa));
    check_eq("c0_rd_b", {16'd0, rdb0}, exp_rd(0, ab));
    check_eq("c0_busy_a", {31'd0, ba0}, exp_busy(0, aa));
    check_eq("c0_busy_b", {31'd0, bb0}, exp_busy(0, ab));
    check_eq("c0_init_done", {31'd0, id0}, {31'd0, rdy_m[0]});
    check_eq("c1_rd_a", {16'd0, rda1}, exp_rd(1, aa));
    check_eq("c1_rd_b", {16'd0, rdb1}, exp_rd(1, ab));
    check_eq("c1_busy_a", {31'd0, ba1}, exp_busy(1, aa));
    check_eq("c1_busy_b", {31'd0, bb1}, exp_busy(1, ab));
    check_eq("c1_init_done", {31'd0, id1}, {31'd0, rdy_m[1]});
  endtask

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        cnt_m[c] = 0;
        rdy_m[c] = 1'b0;
        for (int i = 0; i < 16; i++) busy_m[c][i] = 1'b0;
      end else if (!rdy_m[c]) begin
        mem_m[c][cnt_m[c]] = 16'd0;
        cnt_m[c] = cnt_m[c] + 1;
        if (cnt_m[c] == 16) rdy_m[c] = 1'b1;
      end else begin
        if (we && !(c == 1 && wd == 4'd0)) begin
          mem_m[c][wd] = wdat;
          busy_m[c][wd] = 1'b0;
        end
        if (res && !(c == 1 && ra == 4'd0)) busy_m[c][ra] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] d, input logic [15:0] dat,
                      input logic rs, input logic [3:0] rsa, input logic [3:0] a, input logic [3:0] b,
                      input bit do_chk);
    @(negedge clk);
    rst = r; we = w; wd = d; wdat = dat; res = rs; ra = rsa; aa = a; ab = b;
    #1;
    if (do_chk) check_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n, input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, a, b, 1'b1);
  endtask

  function automatic logic [3:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 4'($urandom_range(0, 3));
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int c = 0; c < 2; c++) begin
      cnt_m[c] = 0;
      rdy_m[c] = 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_m[c][i] = 16'd0;
        busy_m[c][i] = 1'b0;
      end
    end

    // initial reset; DUT state is undefined before it, so no checking
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    idle(17, 4'd1, 4'd2);

    // preload every entry with FFFF and reserve a few
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'(i), 16'hFFFF, 1'b1, 4'(15 - i), 4'(i), 4'(15 - i), 1'b1);

    // reset then watch the sweep: reads must be 0, init_done rises on 16th edge
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd0, 4'd15, 1'b1);
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 4'(i), 16'h5555, 1'b1, 4'(i), 4'(i), 4'(15 - i), 1'b1);
    for (int i = 0; i < 16; i++) idle(1, 4'(i), 4'(15 - i));

    // basic write/read
    step(1'b0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 4'd3, 4'd3, 1'b1);
    idle(1, 4'd5, 4'd3);

    // bypass on r7
    step(1'b0, 1'b1, 4'd7, 16'hBEEF, 1'b0, 4'd0, 4'd7, 4'd5, 1'b1);
    idle(1, 4'd7, 4'd7);

    // scoreboard on r9
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd9, 4'd1, 4'd9, 1'b1);
    idle(1, 4'd1, 4'd9);
    step(1'b0, 1'b1, 4'd9, 16'h0909, 1'b1, 4'd9, 4'd9, 4'd9, 1'b1);
    idle(1, 4'd9, 4'd9);
    step(1'b0, 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 4'd9, 4'd9, 1'b1);
    idle(1, 4'd9, 4'd9);
    step(1'b0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'd0, 4'd4, 4'd4, 1'b1);
    step(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
    idle(1, 4'd4, 4'd4);

    // entry 0 write + reserve
    step(1'b0, 1'b1, 4'd0, 16'hAAAA, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    idle(2, 4'd0, 4'd0);

    // reset mid-sweep with a write to r2 attempted during CLEAR
    step(1'b0, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0, 4'd2, 4'd2, 1'b1);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd2, 4'd2, 1'b1);
    idle(8, 4'd2, 4'd8);
    step(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 4'd2, 4'd2, 1'b1);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 4'd2, 16'hD00D, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1);
    idle(2, 4'd2, 4'd0);

    // randomized traffic with occasional resets
    for (int n = 0; n < 800; n++)
      step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), rnd_addr(),
           16'($urandom), ($urandom_range(0, 2) == 0), rnd_addr(), rnd_addr(), rnd_addr(), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
